solve_sequencer: RTL

SOLVE_SEQUENCER -- requirements
Module: solve_sequencer

---
 rtl/solve_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/solve_sequencer.sv
// Streams puzzle-input bytes from a ROM to a solver and supervises the run.
// Latency: 3 cycles per byte (FETCH, WAIT, STREAM) plus the solver drain time.
// Backpressure: each byte is held stable in STREAM until SolverReady; a watchdog faults on stalls.
module solve_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] InputLen,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [7:0]        RomData,
    output logic [7:0]        SolverData,
    output logic              SolverValid,
    output logic              SolverLast,
    input  logic              SolverReady,
    input  logic              SolverDone,
    input  logic              SolverError,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [1:0]        ErrCode,
    output logic [31:0]       CycleCount
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [1:0] EC_SOLVER  = 2'b01;
    localparam logic [1:0] EC_TIMEOUT = 2'b10;
    localparam logic [1:0] EC_EMPTY   = 2'b11;

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        code_q, code_d;

    logic active;
    logic last_byte;
    logic handshake;
    logic progress;

    assign active    = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                       (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign last_byte = (idx_q == (len_q - ADDR_W'(1)));
    assign handshake = (state_q == S_STREAM) && SolverReady;
    // Completion in the same cycle as the watchdog limit counts as progress.
    assign progress  = handshake || ((state_q == S_DRAIN) && SolverDone);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        if (active) begin
            if (cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
            wd_d = handshake ? '0 : (wd_q + WD_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d = '0;
                    wd_d  = '0;
                    idx_d = '0;
                    len_d = InputLen;
                    if (InputLen == '0) begin
                        state_d = S_FAULT;
                        code_d  = EC_EMPTY;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = RomData;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (SolverReady) begin
                    if (last_byte) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (SolverDone) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_FINISH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase

        // Solver fault overrides everything else, the watchdog overrides normal flow.
        if (active) begin
            if (SolverError) begin
                state_d = S_FAULT;
                code_d  = EC_SOLVER;
            end else if ((wd_q >= WD_LIMIT) && !progress) begin
                state_d = S_FAULT;
                code_d  = EC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign RomAddr     = idx_q;
    assign SolverData  = data_q;
    assign SolverValid = (state_q == S_STREAM);
    assign SolverLast  = (state_q == S_STREAM) && last_byte;
    assign Busy        = active;
    assign Done        = (state_q == S_FINISH);
    assign Error       = (state_q == S_FAULT);
    assign ErrCode     = (state_q == S_FAULT) ? code_q : 2'b00;
    assign CycleCount  = cnt_q;

`ifndef SYNTHESIS
    a_done_error_exclusive : assert property (@(posedge Clk) disable iff (Rst) !(Done && Error));
    a_code_only_on_error   : assert property (@(posedge Clk) disable iff (Rst) (Error || (ErrCode == 2'b00)));
`endif

endmodule
